// File: rtl/reg_master_arb.sv
// Round-robin arbiter sharing one register-access bus among several masters,
// one outstanding transaction at a time, with a timeout that forces completion.
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module reg_master_arb #(
    parameter int NUM_MASTERS    = 2,
    parameter int REG_ADDR_BITS  = 10,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_MASTERS-1:0]                      m_reg_req,
    input  logic [NUM_MASTERS-1:0]                      m_reg_rd_wr_L,
    input  logic [NUM_MASTERS*REG_ADDR_BITS-1:0]        m_reg_addr,
    input  logic [NUM_MASTERS*`CPCI_NF2_DATA_WIDTH-1:0] m_reg_wr_data,
    output logic [NUM_MASTERS-1:0]                      m_reg_ack,
    output logic [NUM_MASTERS*`CPCI_NF2_DATA_WIDTH-1:0] m_reg_rd_data,
    output logic                                        reg_req,
    output logic                                        reg_rd_wr_L,
    output logic [REG_ADDR_BITS-1:0]                    reg_addr,
    output logic [`CPCI_NF2_DATA_WIDTH-1:0]             reg_wr_data,
    input  logic                                        reg_ack,
    input  logic [`CPCI_NF2_DATA_WIDTH-1:0]             reg_rd_data,
    output logic                                        timeout_err
);

    localparam int DW = `CPCI_NF2_DATA_WIDTH;
    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = 16;
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0] TIMEOUT_DATA = DW'(32'hdead_beef);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_t;

    state_t                     state_q;
    logic [GW-1:0]              rr_q;
    logic [GW-1:0]              grant_q;
    logic [CW-1:0]              cnt_q;
    logic                       reg_req_q;
    logic                       reg_rd_wr_L_q;
    logic [REG_ADDR_BITS-1:0]   reg_addr_q;
    logic [DW-1:0]              reg_wr_data_q;
    logic [NUM_MASTERS-1:0]     m_reg_ack_q;
    logic                       timeout_err_q;
    logic [DW-1:0]              rd_data_q [NUM_MASTERS];

    logic [REG_ADDR_BITS-1:0]   addr_arr  [NUM_MASTERS];
    logic [DW-1:0]              wdata_arr [NUM_MASTERS];

    logic                       grant_vld_d;
    logic [GW-1:0]              grant_d;
    logic [GW-1:0]              rr_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_slice
            assign addr_arr[gi]  = m_reg_addr[gi*REG_ADDR_BITS +: REG_ADDR_BITS];
            assign wdata_arr[gi] = m_reg_wr_data[gi*DW +: DW];
            assign m_reg_rd_data[gi*DW +: DW] = rd_data_q[gi];
        end
    endgenerate

    // Scan offsets from the far end so the nearest requester at/after rr_q wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant_vld_d = 1'b0;
        grant_d     = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            if (m_reg_req[idx[GW-1:0]]) begin
                grant_vld_d = 1'b1;
                grant_d     = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        rr_d = (int'(grant_q) == NUM_MASTERS - 1) ? '0 : grant_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_q          <= '0;
            grant_q       <= '0;
            cnt_q         <= '0;
            reg_req_q     <= 1'b0;
            reg_rd_wr_L_q <= 1'b0;
            reg_addr_q    <= '0;
            reg_wr_data_q <= '0;
            m_reg_ack_q   <= '0;
            timeout_err_q <= 1'b0;
            for (int k = 0; k < NUM_MASTERS; k++) begin
                rd_data_q[k] <= '0;
            end
        end else begin
            m_reg_ack_q   <= '0;
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_vld_d) begin
                        grant_q       <= grant_d;
                        reg_req_q     <= 1'b1;
                        reg_rd_wr_L_q <= m_reg_rd_wr_L[grant_d];
                        reg_addr_q    <= addr_arr[grant_d];
                        reg_wr_data_q <= wdata_arr[grant_d];
                        cnt_q         <= '0;
                        state_q       <= REQ;
                    end
                end
                REQ: begin
                    // A downstream ack takes priority over an expiring timeout.
                    if (reg_ack) begin
                        rd_data_q[grant_q]   <= reg_rd_data;
                        reg_req_q            <= 1'b0;
                        m_reg_ack_q[grant_q] <= 1'b1;
                        state_q              <= RESP;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        rd_data_q[grant_q]   <= TIMEOUT_DATA;
                        reg_req_q            <= 1'b0;
                        m_reg_ack_q[grant_q] <= 1'b1;
                        timeout_err_q        <= 1'b1;
                        state_q              <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    rr_q    <= rr_d;
                    state_q <= DRAIN;
                end
                DRAIN: begin
                    // Hold off until both the downstream ack and the served request are gone.
                    if (!reg_ack && !m_reg_req[grant_q]) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign reg_req     = reg_req_q;
    assign reg_rd_wr_L = reg_rd_wr_L_q;
    assign reg_addr    = reg_addr_q;
    assign reg_wr_data = reg_wr_data_q;
    assign m_reg_ack   = m_reg_ack_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_reg_master_arb.sv
// Directed bench for reg_master_arb: two masters, timeout of 8 cycles,
// downstream acks driven by hand from the stimulus sequence.
module tb_reg_master_arb;

    logic        clk;
    logic        reset;
    logic [1:0]  m_reg_req;
    logic [1:0]  m_reg_rd_wr_L;
    logic [19:0] m_reg_addr;
    logic [63:0] m_reg_wr_data;
    logic [1:0]  m_reg_ack;
    logic [63:0] m_reg_rd_data;
    logic        reg_req;
    logic        reg_rd_wr_L;
    logic [9:0]  reg_addr;
    logic [31:0] reg_wr_data;
    logic        reg_ack;
    logic [31:0] reg_rd_data;
    logic        timeout_err;

    int n_assert = 0;
    int n_fail   = 0;
    int idle_low = 0;

    reg_master_arb #(
        .NUM_MASTERS   (2),
        .REG_ADDR_BITS (10),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .m_reg_req    (m_reg_req),
        .m_reg_rd_wr_L(m_reg_rd_wr_L),
        .m_reg_addr   (m_reg_addr),
        .m_reg_wr_data(m_reg_wr_data),
        .m_reg_ack    (m_reg_ack),
        .m_reg_rd_data(m_reg_rd_data),
        .reg_req      (reg_req),
        .reg_rd_wr_L  (reg_rd_wr_L),
        .reg_addr     (reg_addr),
        .reg_wr_data  (reg_wr_data),
        .reg_ack      (reg_ack),
        .reg_rd_data  (reg_rd_data),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream protocol watch: an ack long after the bus went quiet is suspicious.
    always @(negedge clk) begin
        if (reset || reg_req) begin
            idle_low = 0;
        end else begin
            idle_low = idle_low + 1;
            if (reg_ack && idle_low > 2) begin
                $display("protocol note: reg_ack seen with reg_req low for %0d cycles", idle_low);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_m;
        reset         = 1'b1;
        m_reg_req     = 2'b00;
        m_reg_rd_wr_L = 2'b00;
        m_reg_addr    = '0;
        m_reg_wr_data = '0;
        reg_ack       = 1'b0;
        reg_rd_data   = '0;

        // Reset state
        tick();
        tick();
        chk("rst_reg_req", 64'(reg_req), 64'd0);
        chk("rst_m_ack", 64'(m_reg_ack), 64'd0);
        chk("rst_tmo", 64'(timeout_err), 64'd0);
        chk("rst_rd_data", m_reg_rd_data, 64'd0);
        reset = 1'b0;
        tick();

        // Ack while idle is ignored
        reg_ack     = 1'b1;
        reg_rd_data = 32'hffff_ffff;
        tick();
        tick();
        chk("idle_ack_m_ack", 64'(m_reg_ack), 64'd0);
        chk("idle_ack_rd_data", m_reg_rd_data, 64'd0);
        reg_ack = 1'b0;
        tick();

        // Single read by master0, acked three cycles after reg_req rises
        m_reg_req        = 2'b01;
        m_reg_rd_wr_L    = 2'b01;
        m_reg_addr[9:0]  = 10'h004;
        tick();
        chk("rd_reg_req", 64'(reg_req), 64'd1);
        chk("rd_reg_addr", 64'(reg_addr), 64'h004);
        chk("rd_rd_wr_L", 64'(reg_rd_wr_L), 64'd1);
        tick();
        tick();
        chk("rd_wait_m_ack", 64'(m_reg_ack), 64'd0);
        reg_ack     = 1'b1;
        reg_rd_data = 32'h1234_5678;
        tick();
        chk("rd_m_ack", 64'(m_reg_ack), 64'b01);
        chk("rd_slice0", 64'(m_reg_rd_data[31:0]), 64'h1234_5678);
        chk("rd_req_drop", 64'(reg_req), 64'd0);
        chk("rd_tmo", 64'(timeout_err), 64'd0);
        reg_ack   = 1'b0;
        m_reg_req = 2'b00;
        tick();
        chk("rd_ack_pulse", 64'(m_reg_ack), 64'd0);
        tick();
        chk("rd_slice0_hold", 64'(m_reg_rd_data[31:0]), 64'h1234_5678);

        // Write by master1; fields held stable even if the master changes them
        m_reg_req            = 2'b10;
        m_reg_rd_wr_L        = 2'b00;
        m_reg_addr[19:10]    = 10'h3ff;
        m_reg_wr_data[63:32] = 32'ha5a5_0001;
        tick();
        chk("wr_reg_req", 64'(reg_req), 64'd1);
        chk("wr_reg_addr", 64'(reg_addr), 64'h3ff);
        chk("wr_rd_wr_L", 64'(reg_rd_wr_L), 64'd0);
        chk("wr_wr_data", 64'(reg_wr_data), 64'ha5a5_0001);
        m_reg_addr[19:10]    = 10'h155;
        m_reg_wr_data[63:32] = 32'h0;
        tick();
        chk("wr_addr_hold", 64'(reg_addr), 64'h3ff);
        chk("wr_data_hold", 64'(reg_wr_data), 64'ha5a5_0001);
        reg_ack     = 1'b1;
        reg_rd_data = 32'h0bad_0000;
        tick();
        chk("wr_m_ack", 64'(m_reg_ack), 64'b10);
        chk("wr_slice1", 64'(m_reg_rd_data[63:32]), 64'h0bad_0000);
        chk("wr_slice0_keep", 64'(m_reg_rd_data[31:0]), 64'h1234_5678);
        reg_ack   = 1'b0;
        m_reg_req = 2'b00;
        tick();
        tick();

        // Round-robin with both masters requesting continuously
        m_reg_rd_wr_L     = 2'b11;
        m_reg_addr[9:0]   = 10'h010;
        m_reg_addr[19:10] = 10'h020;
        m_reg_req         = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_m = i % 2;
            tick();
            chk("rr_reg_req", 64'(reg_req), 64'd1);
            chk("rr_reg_addr", 64'(reg_addr), (exp_m == 1) ? 64'h020 : 64'h010);
            reg_ack     = 1'b1;
            reg_rd_data = 32'h100 + 32'(i);
            tick();
            chk("rr_m_ack", 64'(m_reg_ack), 64'(2'b01 << exp_m));
            chk("rr_slice", 64'(m_reg_rd_data[exp_m*32 +: 32]), 64'h100 + 64'(i));
            reg_ack          = 1'b0;
            m_reg_req[exp_m] = 1'b0;
            tick();
            tick();
            if (i < 3) m_reg_req[exp_m] = 1'b1;
        end
        m_reg_req = 2'b00;
        tick();

        // Timeout: master0, no downstream ack
        m_reg_addr[9:0] = 10'h055;
        m_reg_req       = 2'b01;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk("tmo_req_high", 64'(reg_req), 64'd1);
            chk("tmo_no_err_yet", 64'(timeout_err), 64'd0);
            tick();
        end
        chk("tmo_req_low", 64'(reg_req), 64'd0);
        chk("tmo_err", 64'(timeout_err), 64'd1);
        chk("tmo_m_ack", 64'(m_reg_ack), 64'b01);
        chk("tmo_slice0", 64'(m_reg_rd_data[31:0]), 64'hdead_beef);
        m_reg_req = 2'b00;
        tick();
        chk("tmo_err_pulse", 64'(timeout_err), 64'd0);
        chk("tmo_ack_pulse", 64'(m_reg_ack), 64'd0);
        tick();

        // Ack on the final timeout cycle, then downstream holds ack two extra cycles
        m_reg_req = 2'b10;
        tick();
        for (int k = 0; k < 7; k++) tick();
        reg_ack     = 1'b1;
        reg_rd_data = 32'h0000_0042;
        tick();
        chk("late_ack_no_err", 64'(timeout_err), 64'd0);
        chk("late_ack_m_ack", 64'(m_reg_ack), 64'b10);
        chk("late_ack_slice1", 64'(m_reg_rd_data[63:32]), 64'h42);
        m_reg_req = 2'b01;
        tick();
        chk("hold_req_low1", 64'(reg_req), 64'd0);
        tick();
        chk("hold_req_low2", 64'(reg_req), 64'd0);
        reg_ack = 1'b0;
        tick();
        chk("hold_req_low3", 64'(reg_req), 64'd0);
        tick();
        chk("hold_next_grant", 64'(reg_req), 64'd1);
        chk("hold_next_addr", 64'(reg_addr), 64'h055);
        reg_ack     = 1'b1;
        reg_rd_data = 32'h0000_0077;
        tick();
        chk("hold_next_m_ack", 64'(m_reg_ack), 64'b01);
        reg_ack   = 1'b0;
        m_reg_req = 2'b00;
        tick();
        tick();

        // Reset two cycles into REQ for master1; afterwards rr restarts at master0
        m_reg_req = 2'b10;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_req", 64'(reg_req), 64'd0);
        chk("mid_rst_m_ack", 64'(m_reg_ack), 64'd0);
        chk("mid_rst_rd_data", m_reg_rd_data, 64'd0);
        reset     = 1'b0;
        m_reg_req = 2'b11;
        tick();
        chk("post_rst_m_ack", 64'(m_reg_ack), 64'd0);
        chk("post_rst_grant0", 64'(reg_addr), 64'h055);
        reg_ack     = 1'b1;
        reg_rd_data = 32'h0000_0099;
        tick();
        chk("post_rst_done", 64'(m_reg_ack), 64'b01);
        chk("post_rst_slice0", 64'(m_reg_rd_data[31:0]), 64'h99);
        reg_ack   = 1'b0;
        m_reg_req = 2'b00;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
